// File: rtl/mac_array_reload_pkg.sv
// Shared definitions for the weight-stationary MAC array.
// Instruction bit positions, instruction width and the saturating clip
// that the accumulate uses when MAC_ARRAY_SAT_EN is defined.
package mac_pkg;

    localparam int INST_LOAD = 0;
    localparam int INST_EXEC = 1;
    localparam int INST_CLR  = 2;
    localparam int INST_W    = 3;

    // Clamp a 33-bit signed sum into the signed range of a w-bit word (w <= 32).
    function automatic logic signed [31:0] sat_clip(input logic signed [32:0] s, input int w);
        logic signed [32:0] hi;
        logic signed [32:0] lo;
        hi = (33'sd1 <<< (w - 1)) - 33'sd1;
        lo = -(33'sd1 <<< (w - 1));
        if (s > hi) return hi[31:0];
        if (s < lo) return lo[31:0];
        return s[31:0];
    endfunction

endpackage

// File: rtl/mac_array_reload_pe.sv
// Single processing element of the weight-stationary array.
// Holds one weight, forwards activation and instruction east one edge later,
// and produces a registered partial sum south. Priority: clear > load > execute.
// MAC_ARRAY_SAT_EN selects a saturating accumulate instead of wrap-around.
module mac_pe_reload
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [bw-1:0]       in_w,
    input  logic [INST_W-1:0]   inst_w,
    input  logic [psum_bw-1:0]  in_n,
    output logic [bw-1:0]       out_e,
    output logic [INST_W-1:0]   inst_e,
    output logic [psum_bw-1:0]  out_s,
    output logic                exec_done
);

    logic [bw-1:0]      w_q;
    logic [bw-1:0]      a_q;
    logic [psum_bw-1:0] psum_q;
    logic [INST_W-1:0]  inst_q;
    logic               load_ready;
    logic               exec_q;

    logic               do_clr;
    logic               do_load;
    logic               do_exec;
    logic [psum_bw-1:0] w_ext;
    logic [psum_bw-1:0] a_ext;
    logic [psum_bw-1:0] prod;
    logic [psum_bw-1:0] sum;
`ifdef MAC_ARRAY_SAT_EN
    logic signed [32:0] sum_wide;
`endif

    // Decode with priority and form in_n + sign(w) * unsigned(a).
    always_comb begin
        do_clr  = inst_w[INST_CLR];
        do_load = !inst_w[INST_CLR] && inst_w[INST_LOAD];
        do_exec = !inst_w[INST_CLR] && !inst_w[INST_LOAD] && inst_w[INST_EXEC];
        w_ext   = {{(psum_bw-bw){w_q[bw-1]}}, w_q};
        a_ext   = {{(psum_bw-bw){1'b0}}, in_w};
        prod    = w_ext * a_ext;
`ifdef MAC_ARRAY_SAT_EN
        // Product fits in psum_bw; only the accumulate can overflow.
        sum_wide = {{(33-psum_bw){in_n[psum_bw-1]}}, in_n}
                 + {{(33-psum_bw){prod[psum_bw-1]}}, prod};
        sum      = psum_bw'(sat_clip(sum_wide, psum_bw));
`else
        sum      = in_n + prod;
`endif
    end

    // PE state: weight capture/forwarding, activation pass-through, accumulate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_q        <= '0;
            a_q        <= '0;
            psum_q     <= '0;
            inst_q     <= '0;
            load_ready <= 1'b1;
            exec_q     <= 1'b0;
        end else begin
            a_q    <= in_w;
            exec_q <= do_exec;
            if (do_clr) begin
                w_q        <= '0;
                load_ready <= 1'b1;
                inst_q     <= inst_w;
            end else if (do_load) begin
                if (load_ready) begin
                    // Weight absorbed here; nothing continues east.
                    w_q        <= in_w;
                    load_ready <= 1'b0;
                    inst_q     <= '0;
                end else begin
                    inst_q <= inst_w;
                end
            end else begin
                inst_q <= inst_w;
                if (do_exec) psum_q <= sum;
            end
        end
    end

    assign out_e     = a_q;
    assign inst_e    = inst_q;
    assign out_s     = psum_q;
    assign exec_done = exec_q;

endmodule

// File: rtl/mac_array_reload.sv
// Weight-stationary systolic MAC array, row x col PEs, with in-place kernel reload.
// Row instruction pipeline skews the wavefront down the rows; each PE skews it east.
// Bottom-row execute flags give a per-column valid aligned with out_s.
// Optional MAC_ARRAY_SAT_EN: saturating accumulate in every PE.
module mac_array_reload
    import mac_pkg::*;
#(
    parameter int bw      = 4,
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int row     = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [row*bw-1:0]      in_w,
    input  logic [psum_bw*col-1:0] in_n,
    input  logic [INST_W-1:0]      inst_w,
    output logic [psum_bw*col-1:0] out_s,
    output logic [col-1:0]         valid
);

    logic [row-1:0][INST_W-1:0]           inst_pipe;
    logic [row-1:0][bw-1:0]               west_a;
    logic [row-1:0][col:0][bw-1:0]        a_h;
    logic [row-1:0][col:0][INST_W-1:0]    inst_h;
    logic [row:0][col-1:0][psum_bw-1:0]   psum_v;
    logic [row-1:0][col-1:0]              exec_v;
    logic                                 unused_east;

    // Row r stage holds an instruction r edges after it was sampled; west data
    // is registered per row so it enters column 0 alongside its instruction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inst_pipe <= '0;
            west_a    <= '0;
        end else begin
            inst_pipe[0] <= inst_w;
            for (int r = 1; r < row; r++) inst_pipe[r] <= inst_pipe[r-1];
            for (int r = 0; r < row; r++) west_a[r] <= in_w[r*bw +: bw];
        end
    end

    for (genvar r = 0; r < row; r++) begin : g_row
        assign a_h[r][0]    = west_a[r];
        assign inst_h[r][0] = inst_pipe[r];
        for (genvar c = 0; c < col; c++) begin : g_col
            mac_pe_reload #(.bw(bw), .psum_bw(psum_bw)) u_pe (
                .clk       (clk),
                .reset     (reset),
                .in_w      (a_h[r][c]),
                .inst_w    (inst_h[r][c]),
                .in_n      (psum_v[r][c]),
                .out_e     (a_h[r][c+1]),
                .inst_e    (inst_h[r][c+1]),
                .out_s     (psum_v[r+1][c]),
                .exec_done (exec_v[r][c])
            );
        end
    end

    for (genvar c = 0; c < col; c++) begin : g_edge
        assign psum_v[0][c]                = in_n[c*psum_bw +: psum_bw];
        assign out_s[c*psum_bw +: psum_bw] = psum_v[row][c];
        assign valid[c]                    = exec_v[row-1][c];
    end

    // East-edge outputs and upper-row execute flags go nowhere: overflow
    // load values simply fall off the array.
    assign unused_east = ^{a_h, inst_h, exec_v};

endmodule

// File: tb/tb_mac_array_reload.sv
// Scoreboard bench for mac_array_reload (3 rows x 4 cols).
// The reference model applies each instruction vector to a weight matrix in
// program order and computes column dot products; a monitor checks outputs.
module tb_mac_array_reload;

    localparam int BW  = 4;
    localparam int PW  = 16;
    localparam int COL = 4;
    localparam int ROW = 3;
    localparam int NH  = 4096;

    logic                clk = 1'b0;
    logic                reset;
    logic [ROW*BW-1:0]   in_w;
    logic [PW*COL-1:0]   in_n;
    logic [2:0]          inst_w;
    logic [PW*COL-1:0]   out_s;
    logic [COL-1:0]      valid;

    mac_array_reload #(.bw(BW), .psum_bw(PW), .col(COL), .row(ROW)) dut (
        .clk    (clk),
        .reset  (reset),
        .in_w   (in_w),
        .in_n   (in_n),
        .inst_w (inst_w),
        .out_s  (out_s),
        .valid  (valid)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    typedef struct { int cyc; logic [PW-1:0] val; } exp_t;

    exp_t          q [COL][$];
    logic [BW-1:0] h_a [NH][ROW];
    logic [PW-1:0] h_n [NH][COL];
    int            w_m [ROW][COL];
    bit            rdy_m [ROW][COL];
    logic [PW-1:0] last_exp [COL];
    int            n_cmp = 0;
    int            n_bad = 0;
    bit            mon_en = 1'b0;

    function automatic void check(string nm, longint act, longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
        end
    endfunction

    function automatic int sx(logic [BW-1:0] v);
        return v[BW-1] ? int'(v) - (1 << BW) : int'(v);
    endfunction

    function automatic int sxp(logic [PW-1:0] v);
        return v[PW-1] ? int'(v) - (1 << PW) : int'(v);
    endfunction

    function automatic int acc_add(int acc, int prod);
        int s;
        s = acc + prod;
`ifdef MAC_ARRAY_SAT_EN
        if (s > (1 << (PW-1)) - 1) s = (1 << (PW-1)) - 1;
        if (s < -(1 << (PW-1)))    s = -(1 << (PW-1));
        return s;
`else
        return sxp(PW'(s));
`endif
    endfunction

    // Reference: whole-vector semantics of one instruction, in program order.
    function automatic void model_step(logic [2:0] inst, logic [ROW*BW-1:0] acts,
                                       logic [COL*PW-1:0] ns, int e);
        int   acc;
        exp_t x;
        if (inst[2]) begin
            for (int r = 0; r < ROW; r++)
                for (int c = 0; c < COL; c++) begin
                    w_m[r][c] = 0; rdy_m[r][c] = 1'b1;
                end
        end else if (inst[0]) begin
            for (int r = 0; r < ROW; r++) begin
                for (int c = 0; c < COL; c++) begin
                    if (rdy_m[r][c]) begin
                        w_m[r][c] = sx(acts[r*BW +: BW]);
                        rdy_m[r][c] = 1'b0;
                        break;
                    end
                end
            end
        end else if (inst[1]) begin
            for (int c = 0; c < COL; c++) begin
                acc = sxp(ns[c*PW +: PW]);
                for (int r = 0; r < ROW; r++)
                    acc = acc_add(acc, w_m[r][c] * int'(acts[r*BW +: BW]));
                x.cyc = e + ROW + c;
                x.val = PW'(acc);
                q[c].push_back(x);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++) begin
                w_m[r][c] = 0; rdy_m[r][c] = 1'b1;
            end
        for (int c = 0; c < COL; c++) begin
            q[c].delete();
            last_exp[c] = '0;
        end
        for (int i = 0; i < NH; i++) begin
            for (int r = 0; r < ROW; r++) h_a[i][r] = '0;
            for (int c = 0; c < COL; c++) h_n[i][c] = '0;
        end
    endfunction

    // Issue one instruction vector; lanes of older vectors are replayed with their skew.
    task automatic issue(input logic [2:0] inst, input logic [ROW*BW-1:0] acts,
                         input logic [COL*PW-1:0] ns);
        int e;
        int idx;
        e = edge_cnt + 1;
        if (e >= NH) begin
            $display("FAIL history_limit: edge %0d, limit %0d", e, NH);
            $fatal(1, "history exhausted");
        end
        for (int r = 0; r < ROW; r++) h_a[e][r] = acts[r*BW +: BW];
        for (int c = 0; c < COL; c++) h_n[e][c] = ns[c*PW +: PW];
        inst_w = inst;
        for (int r = 0; r < ROW; r++) begin
            idx = e - r;
            in_w[r*BW +: BW] = (idx >= 0) ? h_a[idx][r] : '0;
        end
        for (int c = 0; c < COL; c++) begin
            idx = e - 1 - c;
            in_n[c*PW +: PW] = (idx >= 0) ? h_n[idx][c] : '0;
        end
        model_step(inst, acts, ns, e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(3'b000, '0, '0);
    endtask

    task automatic do_reset(input string nm);
        reset  = 1'b1;
        inst_w = '0;
        in_w   = '0;
        in_n   = '0;
        #1;
        check({nm, "_valid"}, valid, 0);
        check({nm, "_out_s"}, out_s, 0);
        model_reset();
        @(posedge clk); @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Monitor: pop and compare on each valid lane; otherwise out_s must hold.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            for (int c = 0; c < COL; c++) begin
                if (valid[c]) begin
                    if (q[c].size() == 0) begin
                        check($sformatf("spurious_valid_c%0d", c), 1, 0);
                    end else begin
                        check($sformatf("latency_c%0d", c), edge_cnt, q[c][0].cyc);
                        check($sformatf("out_s_c%0d", c), out_s[c*PW +: PW], q[c][0].val);
                        last_exp[c] = q[c][0].val;
                        void'(q[c].pop_front());
                    end
                end else begin
                    check($sformatf("hold_c%0d", c), out_s[c*PW +: PW], last_exp[c]);
                    if (q[c].size() != 0 && q[c][0].cyc <= edge_cnt) begin
                        check($sformatf("missing_valid_c%0d", c), 0, 1);
                        void'(q[c].pop_front());
                    end
                end
            end
        end
    end

    function automatic logic [2:0] rnd_inst();
        int p;
        p = $urandom_range(0, 99);
        if (p < 50) return 3'b010;
        if (p < 65) return 3'b001;
        if (p < 73) return 3'b100;
        if (p < 88) return 3'b000;
        return 3'($urandom_range(0, 7));
    endfunction

    int                  wt [ROW][COL] = '{'{3, -2, 5, -8}, '{1, 4, -1, 7}, '{2, -3, 6, 0}};
    logic [ROW*BW-1:0]   acts;
    logic [COL*PW-1:0]   ns;

    initial begin
        reset  = 1'b1;
        inst_w = '0;
        in_w   = '0;
        in_n   = '0;
        #1;
        check("reset_valid", valid, 0);
        check("reset_out_s", out_s, 0);
        model_reset();
        @(posedge clk); #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Full load, then single execute with in_n = 0.
        for (int j = 0; j < COL; j++) begin
            for (int r = 0; r < ROW; r++) acts[r*BW +: BW] = BW'(wt[r][j]);
            issue(3'b001, acts, '0);
        end
        acts = {4'd9, 4'd2, 4'd5};
        issue(3'b010, acts, '0);
        idle(ROW + COL + 2);

        // Three back-to-back executes with random activations and in_n.
        for (int i = 0; i < 3; i++) issue(3'b010, (ROW*BW)'($urandom()), {$urandom(), $urandom()});
        idle(ROW + COL + 2);

        // Reload: clear, load all-ones, execute with activation 7 everywhere.
        issue(3'b100, '0, '0);
        for (int j = 0; j < COL; j++) issue(3'b001, {ROW{4'd1}}, '0);
        issue(3'b010, {ROW{4'd7}}, '0);
        idle(ROW + COL + 2);

        // All bits set acts as clear; col+1 loads drop the last; load+exec is a load.
        issue(3'b111, {ROW{4'd5}}, '0);
        for (int j = 0; j <= COL; j++) issue(3'b001, (ROW*BW)'($urandom()), '0);
        issue(3'b011, (ROW*BW)'($urandom()), '0);
        issue(3'b010, (ROW*BW)'($urandom()), {$urandom(), $urandom()});
        idle(ROW + COL + 2);

        // Reset mid-wavefront, then execute shows in_n pass-through.
        for (int i = 0; i < 3; i++) issue(3'b010, (ROW*BW)'($urandom()), {$urandom(), $urandom()});
        do_reset("midreset");
        issue(3'b010, (ROW*BW)'($urandom()), {$urandom(), $urandom()});
        issue(3'b010, {ROW{4'd15}}, {COL{16'd1234}});
        idle(ROW + COL + 2);

        // Accumulate overflow: in_n near the top, weight 7, activation 15.
        issue(3'b100, '0, '0);
        for (int j = 0; j < COL; j++) issue(3'b001, {ROW{4'd7}}, '0);
        issue(3'b010, {ROW{4'd15}}, {COL{16'd32760}});
        issue(3'b010, {ROW{4'd15}}, {COL{16'h8005}});
        idle(ROW + COL + 2);

        // Random mixed traffic.
        issue(3'b100, '0, '0);
        for (int i = 0; i < 400; i++) begin
            ns = {$urandom(), $urandom()};
            issue(rnd_inst(), (ROW*BW)'($urandom()), ns);
        end
        idle(ROW + COL + 4);

        for (int c = 0; c < COL; c++) check($sformatf("drain_c%0d", c), q[c].size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_array_reload.md
Name: mac_array_reload

Overview:
- Parametrised weight-stationary systolic MAC array, row x col PEs; next generation of the team's 8x8 array.
- New versus the previous generation:
  - in-place kernel reload via a clear instruction, with no global reset needed;
  - per-column output valid that follows the skewed wavefront;
  - a defined instruction priority.
- Sits between the L0/activation FIFO (west) and the output FIFO/accumulator (south).

Parameters:
- bw, 4, activation/weight width (activation unsigned, weight signed two's complement)
- psum_bw, 16, partial-sum width (signed)
- col, 8, PE columns / output channels
- row, 8, PE rows / input channels

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- in_w  input  row*bw  west data; lane r = in_w[r*bw +: bw]
- in_n  input  psum_bw*col  north psum injection; lane c = in_n[c*psum_bw +: psum_bw]
- inst_w  input  3  bit0 kernel load, bit1 execute, bit2 clear (kernel reload)
- out_s  output  psum_bw*col  south psum of bottom row, lane c
- valid  output  col  valid[c]: out_s lane c holds a fresh execute result this cycle

Behaviour:
- Reset (async, active-high):
  - every PE: w_q=0, a_q=0, psum_q=0, inst_q=0, load_ready=1;
  - array inst pipeline=0;
  - out_s=0, valid=0.
- Instruction skew:
  - inst_w is sampled at edge k into row-0 stage; row r stage holds it after edge k+r.
  - Within a row, inst moves one PE east per edge.
  - PE(r,c) acts at edge k+1+r+c.
- Data skew:
  - in_w lane r must be driven in the cycle before edge k+r.
  - The PE captures data together with inst.
  - Data and inst travel east together (a_q forwarded).
- Priority inside a PE: clear > load > execute. Lower-priority bits are ignored when a higher one is set.
- Clear: w_q<=0, load_ready<=1, psum_q unchanged, valid not raised.
- Load, load_ready=1: w_q<=in data, load_ready<=0, nothing forwarded east (east sees inst=0).
- Load, load_ready=0: data and load inst forwarded east unchanged.
- Load fill order: row r needs col consecutive load cycles; first value lands in col 0, last in col col-1.
- Load, extra: a (col+1)th load value exits the east edge and is discarded.
- Execute: psum_q <= in_n_lane + sign_ext(w_q) * zero_ext(a) in psum_bw bits, wrapping by default.
- In_n chain: row 0 takes in_n; row r>0 takes row r-1 psum_q.
- Idle cycles (inst=0): psum_q and w_q hold.
- Latency: out_s lane c and valid[c]=1 appear after edge k+row+c, i.e. row+c edges after the sampling edge.
  - valid[c] is a one-cycle pulse per execute cycle.
  - Back-to-back executes give a continuous valid.
- out_s holds its last value while valid=0.
- Mixed traffic: load, clear and execute may stream back-to-back. Each PE obeys per-cycle priority as the wavefront passes, with no bubbles required.
- Reset mid-operation:
  - all in-flight instructions are dropped;
  - valid drops immediately (async);
  - loaded weights are lost.

Optional Feature:
- Macro: MAC_ARRAY_SAT_EN.
- Defined: the execute add saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1].
- Undefined: two's-complement wrap.
- Products never overflow for psum_bw >= 2*bw+1; only the accumulate saturates.

Decomposition:
- Package mac_pkg holds:
  - INST_LOAD=0, INST_EXEC=1, INST_CLR=2 bit indices;
  - INST_W=3;
  - the saturating-add function, used under MAC_ARRAY_SAT_EN.
- One sub-module, mac_pe_reload: a single PE with w_q/a_q/psum_q/inst_q/load_ready and its east/south ports.
- The top level is only the generate grid, the row inst pipeline and bottom-row valid extraction.

Test Plan:
- Full load then single execute:
  - stimulus: 2x2, bw=4, psum_bw=16; load weights row0={3,-2}, row1={1,4}; execute acts={5,2}, in_n=0;
  - expected: out_s col0=17, col1=-2; valid[0] after 2 edges, valid[1] after 3 edges.
- Streaming executes:
  - stimulus: 3 consecutive execute vectors;
  - expected: valid[c] high 3 consecutive cycles per column, with results matching a golden model and the column skew.
- Reload:
  - stimulus: clear, then load new weights all 1, execute acts=7;
  - expected: out_s each column = row*7; no valid during clear/load.
- Priority and overflow load:
  - stimulus: inst_w=3'b111 → treated as clear only, no valid; col+1 loads → last value discarded, weights = first col values.
- Reset during execute:
  - stimulus: assert reset mid-wavefront;
  - expected: valid=0 and out_s=0 immediately; after release, execute gives in_n pass-through (weights 0).
- Saturation:
  - stimulus: with MAC_ARRAY_SAT_EN, in_n=32760, weight 7, act 15;
  - expected: out_s=32767. Without the macro: wrapped to -32671.
